// File: rtl/load_store_unit.sv
// Load/store unit: one access at a time, byte-lane alignment, load extension and a bus-beat timeout.
// Optional macro LSU_MISALIGNED_SPLIT_EN splits misaligned accesses into two beats; when it is undefined, misaligned accesses are rejected.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_width,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_e;

  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_BYTE = 2'b01;
  localparam logic [1:0] W_HALF = 2'b10;
  localparam logic [1:0] W_WORD = 2'b11;

  state_e      state_q, state_d;
  logic        split_q, split_d;
  logic        is_store_q, is_store_d;
  logic [1:0]  width_q, width_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  off_q, off_d;
  logic [3:0]  be_hi_q, be_hi_d;
  logic [31:0] wdata_hi_q, wdata_hi_d;
  logic [31:0] rdata_lo_q, rdata_lo_d;
  logic [31:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;

  logic [1:0]  req_off;
  logic [3:0]  req_be_base;
  logic [31:0] req_wdata_m;
  logic        req_misaligned;
  logic [7:0]  req_be_lanes;
  logic [63:0] req_wd_lanes;
  logic        issue;

  logic [63:0] ld_pair;
  logic [31:0] ld_word;
  logic [31:0] ld_ext;
  logic        timed_out;

  assign req_off = req_addr[1:0];

  always_comb begin
    req_be_base = '0;
    req_wdata_m = '0;
    case (req_width)
      W_BYTE: begin
        req_be_base = 4'b0001;
        req_wdata_m = {24'b0, req_wdata[7:0]};
      end
      W_HALF: begin
        req_be_base = 4'b0011;
        req_wdata_m = {16'b0, req_wdata[15:0]};
      end
      W_WORD: begin
        req_be_base = 4'b1111;
        req_wdata_m = req_wdata;
      end
      default: ;
    endcase
  end

  assign req_misaligned = ((req_width == W_HALF) && (req_off == 2'd3)) ||
                          ((req_width == W_WORD) && (req_off != 2'd0));

  // Upper halves hold the lanes that spill into the following word (second beat).
  assign req_be_lanes = {4'b0, req_be_base} << req_off;
  assign req_wd_lanes = {32'b0, req_wdata_m} << {req_off, 3'b000};

  assign ld_pair = (state_q == BEAT2) ? {mem_rdata, rdata_lo_q} : {32'b0, mem_rdata};
  assign ld_word = 32'(ld_pair >> {off_q, 3'b000});

  always_comb begin
    ld_ext = '0;
    case (width_q)
      W_BYTE: ld_ext = unsigned_q ? {24'b0, ld_word[7:0]}  : {{24{ld_word[7]}}, ld_word[7:0]};
      W_HALF: ld_ext = unsigned_q ? {16'b0, ld_word[15:0]} : {{16{ld_word[15]}}, ld_word[15:0]};
      W_WORD: ld_ext = ld_word;
      default: ld_ext = '0;
    endcase
  end

  assign timed_out = (TIMEOUT_CYCLES != 0) && (cnt_q == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d      = state_q;
    split_d      = split_q;
    is_store_d   = is_store_q;
    width_d      = width_q;
    unsigned_d   = unsigned_q;
    off_d        = off_q;
    be_hi_d      = be_hi_q;
    wdata_hi_d   = wdata_hi_q;
    rdata_lo_d   = rdata_lo_q;
    cnt_d        = cnt_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    issue        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          is_store_d = req_is_store;
          width_d    = req_width;
          unsigned_d = req_unsigned;
          off_d      = req_off;
          split_d    = 1'b0;
          if (req_width == W_NONE) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
          end else if (req_misaligned) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
            split_d = 1'b1;
            issue   = 1'b1;
`else
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
`endif
          end else begin
            issue = 1'b1;
          end
        end
      end
      BEAT1, BEAT2: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if ((state_q == BEAT1) && split_q) begin
            state_d     = BEAT2;
            rdata_lo_d  = mem_rdata;
            mem_req_d   = 1'b1;
            mem_we_d    = is_store_q;
            mem_addr_d  = mem_addr_q + 32'd4;
            mem_be_d    = be_hi_q;
            mem_wdata_d = wdata_hi_q;
            cnt_d       = '0;
          end else begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = is_store_q ? '0 : ld_ext;
          end
        end else if (timed_out) begin
          mem_req_d    = 1'b0;
          mem_we_d     = 1'b0;
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      state_d     = BEAT1;
      mem_req_d   = 1'b1;
      mem_we_d    = req_is_store;
      mem_addr_d  = {req_addr[31:2], 2'b00};
      mem_be_d    = req_be_lanes[3:0];
      mem_wdata_d = req_is_store ? req_wd_lanes[31:0] : '0;
      be_hi_d     = req_be_lanes[7:4];
      wdata_hi_d  = req_is_store ? req_wd_lanes[63:32] : '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      split_q      <= 1'b0;
      is_store_q   <= 1'b0;
      width_q      <= W_NONE;
      unsigned_q   <= 1'b0;
      off_q        <= '0;
      be_hi_q      <= '0;
      wdata_hi_q   <= '0;
      rdata_lo_q   <= '0;
      cnt_q        <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      split_q      <= split_d;
      is_store_q   <= is_store_d;
      width_q      <= width_d;
      unsigned_q   <= unsigned_d;
      off_q        <= off_d;
      be_hi_q      <= be_hi_d;
      wdata_hi_q   <= wdata_hi_d;
      rdata_lo_q   <= rdata_lo_d;
      cnt_q        <= cnt_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (TIMEOUT_CYCLES=4); follows LSU_MISALIGNED_SPLIT_EN if defined.
module tb_load_store_unit;
  localparam int unsigned TO = 4;
  localparam logic [1:0] W_NONE = 2'b00;
  localparam logic [1:0] W_BYTE = 2'b01;
  localparam logic [1:0] W_HALF = 2'b10;
  localparam logic [1:0] W_WORD = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_is_store, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_width;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_addr(req_addr), .req_width(req_width), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct packed {
    logic        st;
    logic [31:0] a;
    logic [1:0]  w;
    logic        u;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] ea;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] erd;
  } vec_t;

  // Presents one request for a single cycle starting at a falling edge.
  task automatic send(input logic st, input logic [31:0] a, input logic [1:0] w,
                      input logic u, input logic [31:0] wd);
    req_valid = 1'b1; req_is_store = st; req_addr = a; req_width = w;
    req_unsigned = u; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({resp_valid, resp_err, mem_req, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000", {resp_valid, resp_err, mem_req, mem_we});
    end
    checks++;
    if ({mem_addr, mem_wdata, mem_be, resp_rdata} !== '0) begin
      errors++; $display("FAIL reset_data got %h %h %h %h exp all 0", mem_addr, mem_wdata, mem_be, resp_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
  endtask

  task automatic test_load_byte();
    logic [31:0] exp_rd [2];
    exp_rd[0] = 32'hFFFFFF80;
    exp_rd[1] = 32'h00000080;
    for (int i = 0; i < 2; i++) begin
      send(1'b0, 32'h103, W_BYTE, 1'(i), 32'h0);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, 1'b0, 32'h100, 4'b1000}) begin
        errors++; $display("FAIL lb_beat[%0d] got req=%b we=%b addr=%h be=%b exp 1 0 00000100 1000", i, mem_req, mem_we, mem_addr, mem_be);
      end
      @(negedge clk);
      mem_ack = 1'b1; mem_rdata = 32'h80FFFFFF;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if ({resp_valid, resp_err, resp_rdata, mem_req} !== {1'b1, 1'b0, exp_rd[i], 1'b0}) begin
        errors++; $display("FAIL lb_resp[%0d] got v=%b e=%b d=%h req=%b exp 1 0 %h 0", i, resp_valid, resp_err, resp_rdata, mem_req, exp_rd[i]);
      end
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready} !== 2'b01) begin
        errors++; $display("FAIL lb_idle[%0d] got v=%b rdy=%b exp 0 1", i, resp_valid, req_ready);
      end
    end
  endtask

  task automatic test_store_half();
    send(1'b1, 32'h202, W_HALF, 1'b0, 32'h0000BEEF);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, resp_valid} !==
          {1'b1, 1'b1, 32'h200, 4'b1100, 32'hBEEF0000, 1'b0}) begin
        errors++; $display("FAIL sh_beat[%0d] got req=%b we=%b addr=%h be=%b wd=%h v=%b exp 1 1 00000200 1100 beef0000 0",
                           i, mem_req, mem_we, mem_addr, mem_be, mem_wdata, resp_valid);
      end
      if (i == 3) mem_ack = 1'b1;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_rdata, mem_req} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors++; $display("FAIL sh_resp got v=%b e=%b d=%h req=%b exp 1 0 0 0", resp_valid, resp_err, resp_rdata, mem_req);
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL sh_single_pulse got v=%b rdy=%b exp 0 1", resp_valid, req_ready);
    end
  endtask

  task automatic test_widths();
    vec_t tv [8];
    tv[0] = '{1'b0, 32'h402, W_HALF, 1'b0, 32'h0,        32'h80011234, 32'h400, 4'b1100, 32'h0,        32'hFFFF8001};
    tv[1] = '{1'b0, 32'h400, W_HALF, 1'b0, 32'h0,        32'h1234F00D, 32'h400, 4'b0011, 32'h0,        32'hFFFFF00D};
    tv[2] = '{1'b0, 32'h500, W_WORD, 1'b0, 32'h0,        32'hCAFEBABE, 32'h500, 4'b1111, 32'h0,        32'hCAFEBABE};
    tv[3] = '{1'b0, 32'h102, W_BYTE, 1'b1, 32'h0,        32'h00AB0000, 32'h100, 4'b0100, 32'h0,        32'h000000AB};
    tv[4] = '{1'b1, 32'h601, W_BYTE, 1'b0, 32'h123456A5, 32'h0,        32'h600, 4'b0010, 32'h0000A500, 32'h0};
    tv[5] = '{1'b1, 32'h201, W_HALF, 1'b0, 32'hFFFF1234, 32'h0,        32'h200, 4'b0110, 32'h00123400, 32'h0};
    tv[6] = '{1'b1, 32'h700, W_WORD, 1'b0, 32'hDEADBEEF, 32'h0,        32'h700, 4'b1111, 32'hDEADBEEF, 32'h0};
    tv[7] = '{1'b0, 32'h006, W_HALF, 1'b1, 32'h0,        32'hFEDC0000, 32'h004, 4'b1100, 32'h0,        32'h0000FEDC};
    for (int i = 0; i < 8; i++) begin
      send(tv[i].st, tv[i].a, tv[i].w, tv[i].u, tv[i].wd);
      checks++;
      if ({mem_req, mem_we, mem_addr, mem_be} !== {1'b1, tv[i].st, tv[i].ea, tv[i].ebe}) begin
        errors++; $display("FAIL width_beat[%0d] got req=%b we=%b addr=%h be=%b exp 1 %b %h %b",
                           i, mem_req, mem_we, mem_addr, mem_be, tv[i].st, tv[i].ea, tv[i].ebe);
      end
      if (tv[i].st) begin
        checks++;
        if (mem_wdata !== tv[i].ewd) begin
          errors++; $display("FAIL width_wdata[%0d] got %h exp %h", i, mem_wdata, tv[i].ewd);
        end
      end
      mem_ack = 1'b1; mem_rdata = tv[i].rd;
      @(negedge clk);
      mem_ack = 1'b0;
      checks++;
      if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, tv[i].erd}) begin
        errors++; $display("FAIL width_resp[%0d] got v=%b e=%b d=%h exp 1 0 %h", i, resp_valid, resp_err, resp_rdata, tv[i].erd);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_none();
    for (int i = 0; i < 2; i++) begin
      send(1'(i), 32'h123, W_NONE, 1'b0, 32'hFFFFFFFF);
      checks++;
      if ({resp_valid, resp_err, resp_rdata, mem_req} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
        errors++; $display("FAIL none_resp[%0d] got v=%b e=%b d=%h req=%b exp 1 0 0 0", i, resp_valid, resp_err, resp_rdata, mem_req);
      end
      @(negedge clk);
      checks++;
      if ({resp_valid, req_ready, mem_req} !== 3'b010) begin
        errors++; $display("FAIL none_idle[%0d] got v=%b rdy=%b req=%b exp 0 1 0", i, resp_valid, req_ready, mem_req);
      end
    end
  endtask

  task automatic test_misaligned();
`ifdef LSU_MISALIGNED_SPLIT_EN
    send(1'b0, 32'h101, W_WORD, 1'b0, 32'h0);
    checks++;
    if ({mem_req, mem_addr, mem_be} !== {1'b1, 32'h100, 4'b1110}) begin
      errors++; $display("FAIL split_lw_b1 got req=%b addr=%h be=%b exp 1 00000100 1110", mem_req, mem_addr, mem_be);
    end
    mem_ack = 1'b1; mem_rdata = 32'h44332211;
    @(negedge clk);
    mem_rdata = 32'h88776655;
    checks++;
    if ({mem_req, mem_addr, mem_be, resp_valid} !== {1'b1, 32'h104, 4'b0001, 1'b0}) begin
      errors++; $display("FAIL split_lw_b2 got req=%b addr=%h be=%b v=%b exp 1 00000104 0001 0", mem_req, mem_addr, mem_be, resp_valid);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_rdata, mem_req} !== {1'b1, 1'b0, 32'h55443322, 1'b0}) begin
      errors++; $display("FAIL split_lw_resp got v=%b e=%b d=%h req=%b exp 1 0 55443322 0", resp_valid, resp_err, resp_rdata, mem_req);
    end
    @(negedge clk);
    send(1'b1, 32'hFFFFFFFE, W_WORD, 1'b0, 32'hAABBCCDD);
    checks++;
    if ({mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 32'hFFFFFFFC, 4'b1100, 32'hCCDD0000}) begin
      errors++; $display("FAIL split_sw_b1 got we=%b addr=%h be=%b wd=%h exp 1 fffffffc 1100 ccdd0000", mem_we, mem_addr, mem_be, mem_wdata);
    end
    mem_ack = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== {1'b1, 1'b1, 32'h0, 4'b0011, 32'h0000AABB}) begin
      errors++; $display("FAIL split_sw_b2 got req=%b we=%b addr=%h be=%b wd=%h exp 1 1 0 0011 0000aabb", mem_req, mem_we, mem_addr, mem_be, mem_wdata);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL split_sw_resp got v=%b e=%b d=%h exp 1 0 0", resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk);
`else
    logic [31:0] addrs [2];
    logic [1:0]  widths [2];
    addrs[0] = 32'h101; widths[0] = W_WORD;
    addrs[1] = 32'h003; widths[1] = W_HALF;
    for (int i = 0; i < 2; i++) begin
      send(1'b0, addrs[i], widths[i], 1'b0, 32'h0);
      checks++;
      if ({resp_valid, resp_err, resp_rdata, mem_req} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
        errors++; $display("FAIL misal_resp[%0d] got v=%b e=%b d=%h req=%b exp 1 1 0 0", i, resp_valid, resp_err, resp_rdata, mem_req);
      end
      @(negedge clk);
      checks++;
      if ({mem_req, resp_valid, req_ready} !== 3'b001) begin
        errors++; $display("FAIL misal_idle[%0d] got req=%b v=%b rdy=%b exp 0 0 1", i, mem_req, resp_valid, req_ready);
      end
    end
`endif
  endtask

  task automatic test_timeout();
    send(1'b0, 32'h300, W_WORD, 1'b0, 32'h0);
    for (int i = 0; i < int'(TO); i++) begin
      checks++;
      if ({mem_req, resp_valid} !== 2'b10) begin
        errors++; $display("FAIL timeout_wait[%0d] got req=%b v=%b exp 1 0", i, mem_req, resp_valid);
      end
      @(negedge clk);
    end
    checks++;
    if ({resp_valid, resp_err, resp_rdata, mem_req} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      errors++; $display("FAIL timeout_resp got v=%b e=%b d=%h req=%b exp 1 1 0 0", resp_valid, resp_err, resp_rdata, mem_req);
    end
    @(negedge clk);
  endtask

  task automatic test_ignored();
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({resp_valid, mem_req, req_ready} !== 3'b001) begin
      errors++; $display("FAIL idle_ack got v=%b req=%b rdy=%b exp 0 0 1", resp_valid, mem_req, req_ready);
    end
    send(1'b0, 32'h900, W_WORD, 1'b0, 32'h0);
    send(1'b1, 32'hA00, W_WORD, 1'b0, 32'h55555555);
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h900}) begin
      errors++; $display("FAIL busy_req got req=%b we=%b addr=%h exp 1 0 00000900", mem_req, mem_we, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({resp_valid, resp_rdata} !== {1'b1, 32'h0BADF00D}) begin
      errors++; $display("FAIL busy_resp got v=%b d=%h exp 1 0badf00d", resp_valid, resp_rdata);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, resp_valid, req_ready} !== 3'b001) begin
      errors++; $display("FAIL busy_no_latch got req=%b v=%b rdy=%b exp 0 0 1", mem_req, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    send(1'b1, 32'h800, W_WORD, 1'b0, 32'h11111111);
    checks++;
    if ({mem_req, mem_we} !== 2'b11) begin
      errors++; $display("FAIL rst_mid_beat got req=%b we=%b exp 1 1", mem_req, mem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL rst_async got req=%b we=%b addr=%h exp 0 0 0", mem_req, mem_we, mem_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (resp_valid) pulses++;
      @(negedge clk);
    end
    checks++;
    if ({pulses, req_ready} !== {32'd0, 1'b1}) begin
      errors++; $display("FAIL rst_no_resp got pulses=%0d rdy=%b exp 0 1", pulses, req_ready);
    end
    send(1'b0, 32'h0, W_WORD, 1'b0, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_ack = 1'b0;
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 32'h12345678}) begin
      errors++; $display("FAIL rst_after_lw got v=%b e=%b d=%h exp 1 0 12345678", resp_valid, resp_err, resp_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    req_valid = 1'b0; req_is_store = 1'b0; req_addr = '0; req_width = W_NONE;
    req_unsigned = 1'b0; req_wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_load_byte();
    test_store_half();
    test_widths();
    test_none();
    test_misaligned();
    test_timeout();
    test_ignored();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max cycles a bus beat waits for mem_ack before abort; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  execute stage presents an access.
REQ-005 req_ready  output  1  unit can accept; high only in IDLE.
REQ-006 req_is_store  input  1  1 = store, 0 = load.
REQ-007 req_addr  input  32  byte address (ALU sum).
REQ-008 req_width  input  2  2'b00 NONE, 2'b01 BYTE, 2'b10 HALF, 2'b11 WORD.
REQ-009 req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse (loads and stores).
REQ-012 resp_rdata  output  32  extended load data; 0 for stores, NONE, errors.
REQ-013 resp_err  output  1  qualifies resp_valid: access aborted.
REQ-014 mem_req / mem_we  output  1 each  bus beat request / write strobe.
REQ-015 mem_addr  output  32  word-aligned beat address (bits[1:0]=0).
REQ-016 mem_wdata / mem_be  output  32 / 4  lane-positioned data / byte enables.
REQ-017 mem_ack / mem_rdata  input  1 / 32  beat completion / read data valid with ack.

Function
REQ-018 FSM states IDLE, BEAT1, BEAT2, RESP; handshake req_valid&&req_ready in IDLE latches all req_* fields.
REQ-019 Accept in cycle N -> mem_req=1 from N+1; mem_* held stable until the cycle mem_ack=1; mem_req=0 the cycle after ack.
REQ-020 Single-beat access: ack in cycle M -> RESP, resp_valid=1 in M+1 only, then IDLE (req_ready=1 in M+2).
REQ-021 Width NONE: no bus beat; resp_valid=1, resp_rdata=0 in N+1.
REQ-022 Offset off=addr[1:0]; mem_be: BYTE 4'b0001<<off, HALF 4'b0011<<off, WORD 4'b1111<<off, truncated to 4 bits for beat 1.
REQ-023 mem_wdata = req_wdata shifted left by 8*off (beat 1); lanes outside mem_be don't-care but driven 0.
REQ-024 Load: byte/half selected from mem_rdata at lane off, then extended per req_unsigned to 32 bits.
REQ-025 Misaligned = HALF with off=3, or WORD with off!=0.
REQ-026 Timeout: counter reset each beat start; reaching TIMEOUT_CYCLES without ack -> drop mem_req, RESP with resp_err=1.
REQ-027 mem_ack outside BEAT1/BEAT2 ignored; req_valid outside IDLE ignored (no latch).

Reset
REQ-028 rst_n low asynchronously forces IDLE, resp_valid=0, resp_rdata=0, resp_err=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, timeout counter 0.
REQ-029 Reset mid-transaction abandons it immediately; no resp_valid emitted for it; req_ready=1 first cycle after rst_n rises.

Configuration
REQ-030 Macro LSU_MISALIGNED_SPLIT_EN defined: misaligned access issues BEAT1 at addr&~3 with upper lanes, then BEAT2 at (addr&~3)+4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000) with remaining lanes mem_be>>(4-off), data shifted right by 8*(4-off); load bytes merged from both beats; resp_valid one cycle after BEAT2 ack.
REQ-031 Macro undefined: misaligned access issues no bus beat; resp_valid=1, resp_err=1, resp_rdata=0 in N+1; BEAT2 state unreachable.

Verification
REQ-032 LB addr 0x103, mem_rdata 0x80FFFFFF, ack 1 cycle after req -> mem_be=4'b1000, resp_rdata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-033 SH addr 0x202, wdata 0x0000BEEF, ack after 3 wait cycles -> mem_addr=0x200, mem_be=4'b1100, mem_wdata=0xBEEF0000 stable all 4 cycles, one resp_valid, err=0.
REQ-034 LW addr 0x101 (split enabled), beats return 0x44332211 then 0x88776655 -> mem_addr 0x100 be 1110, then 0x104 be 0001, resp_rdata=0x55443322; split disabled -> resp_err=1, no mem_req.
REQ-035 LW addr 0x300 with mem_ack never asserted, TIMEOUT_CYCLES=4 -> mem_req high 4 cycles, then resp_valid=1, resp_err=1, resp_rdata=0.
REQ-036 rst_n pulsed low during BEAT1 of SW -> mem_req=0 asynchronously, no resp_valid; next LW addr 0x0 ack 0x12345678 -> resp_rdata=0x12345678.
